// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: generic chain of DEPTH pipeline registers carrying an
// opaque WIDTH-bit payload under valid/ready flow control, with per-stage
// stall and per-stage flush (bubble insertion).
// Optional feature macro: PIPE_PERF_EN enables saturating stall/bubble
// performance counters; when it is undefined both counters read constant 0.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           stall_stage,
  input  logic [DEPTH-1:0]           flush_mask,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;
  logic                        in_ready_s;

  // Ready chain from the sink back to the input, then per-stage next state.
  always_comb begin : chain_comb
    logic [DEPTH:0]              acc_l;  // acc_l[i]: stage i can take an item; acc_l[DEPTH] is the sink
    logic [DEPTH:0]              mv_l;   // mv_l[i]: an item moves into stage i; mv_l[DEPTH] leaves the chain
    logic [DEPTH-1:0][WIDTH-1:0] src_l;  // payload offered to stage i by its upstream neighbour
    acc_l   = {(DEPTH+1){1'b0}};
    mv_l    = {(DEPTH+1){1'b0}};
    src_l   = {(DEPTH*WIDTH){1'b0}};
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = {OCC_W{1'b0}};

    acc_l[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      mv_l[i+1] = valid_q[i] & ~stall_stage[i] & acc_l[i+1];
      // A stalled stage never accepts, even when it is empty.
      acc_l[i]  = ~stall_stage[i] & (~valid_q[i] | mv_l[i+1]);
    end
    mv_l[0]    = in_valid & acc_l[0];
    in_ready_s = acc_l[0];

    src_l[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_l[i] = data_q[i-1];
    end

    // Flush wins over an incoming item (which is discarded, upstream already
    // handed it off) and over stall; bubbles keep stale data.
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_mask[i]) begin
        valid_d[i] = 1'b0;
      end else if (mv_l[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = src_l[i];
      end else if (mv_l[i+1]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  // Stage registers and registered occupancy; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= {DEPTH{1'b0}};
      data_q  <= {(DEPTH*WIDTH){1'b0}};
      occ_q   <= {OCC_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = valid_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign occupancy   = occ_q;

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  // Saturating counters: upstream blocked, and downstream starved.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (in_valid && !in_ready_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (out_ready && !valid_q[DEPTH-1] && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=4): scoreboard queue fed on
// accepted input, drained and compared on consumed output.
`timescale 1ns/1ps
module tb_pipe_stage_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall_stage;
  logic [DEPTH-1:0]       flush_mask;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [OCC_W-1:0]       occupancy;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       bubble_cnt;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [CNT_W-1:0] exp_stall  = '0;
  logic [CNT_W-1:0] exp_bubble = '0;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_stage(stall_stage), .flush_mask(flush_mask),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: observe handshakes before the edge, update the scoreboard
  // and counter model, return at the following falling edge.
  task automatic tick(output bit acc);
    bit oc;
`ifdef PIPE_PERF_EN
    bit sinc;
    bit binc;
`endif
    #1;
    acc = in_valid && in_ready;
    oc  = out_valid && out_ready;
`ifdef PIPE_PERF_EN
    sinc = in_valid && !in_ready;
    binc = out_ready && !out_valid;
`endif
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (oc) begin
        if (sb_q.size() == 0) check_val("sb_spurious", 64'(out_valid), 64'd0);
        else                  check_val("sb_data", 64'(out_data), 64'(sb_q.pop_front()));
      end
      if (acc && !flush_mask[0]) sb_q.push_back(in_data);
    end
    @(posedge clk);
`ifdef PIPE_PERF_EN
    if (!rst) begin
      exp_stall  = '0;
      exp_bubble = '0;
    end else begin
      if (sinc && exp_stall  != {CNT_W{1'b1}}) exp_stall++;
      if (binc && exp_bubble != {CNT_W{1'b1}}) exp_bubble++;
    end
`endif
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    bit a;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sb_q.size() > 0; k++) tick(a);
    check_val(tag, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_cnt(input string tag);
    check_val({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
    check_val({tag, "_bubble_cnt"}, 64'(bubble_cnt), 64'(exp_bubble));
  endtask

  initial begin
    bit a;
    int c;
    int bubbles;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; stall_stage = '0;
    flush_mask = '0; out_ready = 1'b0;
    @(negedge clk);
    tick(a); tick(a);
    rst = 1'b1;
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_stage_valid", 64'(stage_valid), 64'd0);
    check_val("rst_stage_data", 64'(|stage_data), 64'd0);
    check_val("rst_occ", 64'(occupancy), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check_val("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);

    // Stream A0..A9 at full rate.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'hA000_0000 + 32'(i);
      tick(a);
      check_val("a_accept", 64'(a), 64'd1);
      if (i < 4) check_val("a_latency", 64'(out_valid), 64'(i >= 3));
      if (i == 3) check_val("a_occ4", 64'(occupancy), 64'd4);
    end
    drain("a_drain");
    check_cnt("a");

    // Backpressure fills the chain, then pass-through release.
    in_valid = 1'b1; out_ready = 1'b0; c = 0;
    for (int t = 0; t < 6; t++) begin
      in_data = 32'hC000_0000 + 32'(c);
      tick(a);
      if (a) c++;
    end
    check_val("c_accepts", 64'(c), 64'd4);
    #1;
    check_val("c_full_ready", 64'(in_ready), 64'd0);
    check_val("c_full_occ", 64'(occupancy), 64'd4);
    out_ready = 1'b1;
    #1;
    check_val("c_pass_ready", 64'(in_ready), 64'd1);
    for (int t = 0; t < 20 && c < 8; t++) begin
      in_data = 32'hC000_0000 + 32'(c);
      tick(a);
      if (a) c++;
    end
    check_val("c_all_sent", 64'(c), 64'd8);
    drain("c_drain");
    check_cnt("c");

    // Stall stage 1 for 3 cycles mid-stream.
    in_valid = 1'b1; out_ready = 1'b1; c = 0; bubbles = 0;
    for (int t = 0; t < 40 && c < 12; t++) begin
      stall_stage = (t >= 5 && t <= 7) ? 4'b0010 : 4'b0000;
      in_data = 32'hD000_0000 + 32'(c);
      #1;
      if (t >= 5 && t <= 7) check_val("d_stall_ready", 64'(in_ready), 64'd0);
      if (t >= 5 && t <= 8 && !stage_valid[2]) bubbles++;
      tick(a);
      if (a) c++;
    end
    stall_stage = '0;
    check_val("d_bubbles", 64'(bubbles), 64'd3);
    drain("d_drain");
    check_cnt("d");

    // Flush stage 0 while B5 enters: B5 must vanish, B4 must survive.
    in_valid = 1'b1; out_ready = 1'b1; c = 0;
    for (int t = 0; t < 30 && c < 10; t++) begin
      in_data = 32'hB000_0000 + 32'(c);
      flush_mask = (c == 5) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 5) check_val("b_flush_ready", 64'(in_ready), 64'd1);
      tick(a);
      if (a) c++;
    end
    flush_mask = '0;
    drain("b_drain");

    // Flush + stall on stage 2 with the chain full.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hE000_0000 + 32'(i);
      tick(a);
      check_val("e_fill", 64'(a), 64'd1);
    end
    in_valid = 1'b0;
    #1;
    check_val("e_full", 64'(stage_valid), 64'hF);
    flush_mask = 4'b0100; stall_stage = 4'b0100; out_ready = 1'b1;
    tick(a);
    if (sb_q.size() > 0) sb_q.delete(0);  // E1 sat in stage 2 and is killed
    flush_mask = '0; stall_stage = '0;
    #1;
    check_val("e_stage_valid", 64'(stage_valid), 64'h3);
    check_val("e_out_valid", 64'(out_valid), 64'd0);
    drain("e_drain");
    check_cnt("e");

    // Reset with three items in flight.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h6000_0000 + 32'(i);
      tick(a);
    end
    in_valid = 1'b0;
    #1;
    check_val("g_occ3", 64'(occupancy), 64'd3);
    rst = 1'b0;
    tick(a);
    rst = 1'b1;
    #1;
    check_val("g_out_valid", 64'(out_valid), 64'd0);
    check_val("g_out_data", 64'(out_data), 64'd0);
    check_val("g_stage_valid", 64'(stage_valid), 64'd0);
    check_val("g_stage_data", 64'(|stage_data), 64'd0);
    check_val("g_occ", 64'(occupancy), 64'd0);
    check_val("g_stall_cnt", 64'(stall_cnt), 64'd0);
    check_val("g_bubble_cnt", 64'(bubble_cnt), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick(a);
    check_val("g_no_output", 64'(out_valid), 64'd0);
    check_cnt("g");

`ifdef PIPE_PERF_EN
    // Long stall at stage 0 drives stall_cnt into saturation.
    stall_stage = 4'b0001; in_valid = 1'b1; in_data = 32'h5A5A_5A5A;
    for (int i = 0; i < 65540; i++) tick(a);
    check_val("p_stall_sat", 64'(stall_cnt), 64'hFFFF);
    check_cnt("p");
    stall_stage = '0; in_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
